// File: rtl/writeback_unit_if.sv
// writeback_unit_if: issue, execute and memory-return inputs plus register-file write and scoreboard outputs
interface writeback_unit_if #(parameter int AW = 5);
    localparam int NR = 1 << AW;
    logic                 iss_valid, iss_is_vector;
    logic [AW-1:0]        iss_reg;
    logic                 ex_valid, ex_is_vector;
    logic [AW-1:0]        ex_reg;
    logic [35:0]          ex_sdata;
    logic [3:0][31:0]     ex_vdata;
    logic [3:0]           ex_mask;
    logic                 mem_valid, mem_ready, mem_is_vector;
    logic [AW-1:0]        mem_reg;
    logic [35:0]          mem_sdata;
    logic [3:0][31:0]     mem_vdata;
    logic [3:0]           mem_mask;
    logic                 s_wr_en;
    logic [AW-1:0]        r_write_addr, v_write_addr;
    logic [35:0]          write_data;
    logic [3:0][31:0]     write_vector;
    logic [3:0]           mask;
    logic [NR-1:0]        s_busy, v_busy;
    modport master (
        output iss_valid, iss_is_vector, iss_reg,
        output ex_valid, ex_is_vector, ex_reg, ex_sdata, ex_vdata, ex_mask,
        output mem_valid, mem_is_vector, mem_reg, mem_sdata, mem_vdata, mem_mask,
        input  mem_ready, s_wr_en, r_write_addr, write_data, v_write_addr, write_vector, mask,
        input  s_busy, v_busy
    );
    modport slave (
        input  iss_valid, iss_is_vector, iss_reg,
        input  ex_valid, ex_is_vector, ex_reg, ex_sdata, ex_vdata, ex_mask,
        input  mem_valid, mem_is_vector, mem_reg, mem_sdata, mem_vdata, mem_mask,
        output mem_ready, s_wr_en, r_write_addr, write_data, v_write_addr, write_vector, mask,
        output s_busy, v_busy
    );
endinterface

// File: rtl/writeback_unit.sv
// writeback_unit: merges in-order execute results with FIFO-buffered memory returns onto the
// scalar/vector register-file write ports and tracks outstanding writes for hazard stalls.
module writeback_unit #(
    parameter int DEPTH = 4,
    parameter int AW    = 5
) (
    input logic            clk,
    input logic            rst_n,
    writeback_unit_if.slave wb
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int NR = 1 << AW;
    typedef struct packed {
        logic             vec;
        logic [AW-1:0]    rd;
        logic [35:0]      sdata;
        logic [3:0][31:0] vdata;
        logic [3:0]       mask;
    } entry_t;
    entry_t         fifo [DEPTH];
    entry_t         head;
    logic [PW-1:0]  rd_ptr, wr_ptr;
    logic [CW-1:0]  count;
    logic           push, pop, ex_s, ex_v, hd_s, hd_v, v_wr;
    logic [NR-1:0]  s_set, s_clr, v_set, v_clr;
    always_comb begin
        head  = fifo[rd_ptr];
        ex_s  = wb.ex_valid && !wb.ex_is_vector;
        ex_v  = wb.ex_valid && wb.ex_is_vector;
        // the head only yields to ex on its own port; a blocked head stalls everything behind it
        pop   = count != '0 && !(wb.ex_valid && wb.ex_is_vector == head.vec);
        hd_s  = pop && !head.vec;
        hd_v  = pop && head.vec;
        push  = wb.mem_valid && wb.mem_ready;
        s_set = {{(NR-1){1'b0}}, wb.iss_valid && !wb.iss_is_vector} << wb.iss_reg;
        v_set = {{(NR-1){1'b0}}, wb.iss_valid && wb.iss_is_vector} << wb.iss_reg;
        s_clr = {{(NR-1){1'b0}}, wb.s_wr_en} << wb.r_write_addr;
        v_clr = {{(NR-1){1'b0}}, v_wr} << wb.v_write_addr;
    end
    assign wb.mem_ready = rst_n && count != CW'(DEPTH);
    always_ff @(posedge clk)
        if (push) fifo[wr_ptr] <= '{wb.mem_is_vector, wb.mem_reg, wb.mem_sdata, wb.mem_vdata, wb.mem_mask};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            count           <= '0;
            v_wr            <= 1'b0;
            wb.s_wr_en      <= 1'b0;
            wb.r_write_addr <= '0;
            wb.write_data   <= '0;
            wb.v_write_addr <= '0;
            wb.write_vector <= '0;
            wb.mask         <= '0;
            wb.s_busy       <= '0;
            wb.v_busy       <= '0;
        end else begin
            rd_ptr          <= rd_ptr + PW'(pop);
            wr_ptr          <= wr_ptr + PW'(push);
            count           <= count + CW'(push) - CW'(pop);
            wb.s_wr_en      <= ex_s || hd_s;
            wb.r_write_addr <= ex_s ? wb.ex_reg : head.rd;
            wb.write_data   <= ex_s ? wb.ex_sdata : head.sdata;
            // v_wr marks a vector commit even when the mask is all zero, so busy still clears
            v_wr            <= ex_v || hd_v;
            wb.v_write_addr <= ex_v ? wb.ex_reg : head.rd;
            wb.write_vector <= ex_v ? wb.ex_vdata : head.vdata;
            wb.mask         <= ex_v ? wb.ex_mask : hd_v ? head.mask : 4'b0;
            wb.s_busy       <= (wb.s_busy & ~s_clr) | s_set;
            wb.v_busy       <= (wb.v_busy & ~v_clr) | v_set;
        end
    end
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: directed checks of the writeback unit; inputs change and outputs are sampled on negedge.
module tb_writeback_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    writeback_unit_if #(.AW(5)) wb();
    writeback_unit #(.DEPTH(4), .AW(5)) dut (.clk(clk), .rst_n(rst_n), .wb(wb));
    always #5 clk = ~clk;

    task automatic idle();
        wb.iss_valid = 0; wb.iss_is_vector = 0; wb.iss_reg = '0;
        wb.ex_valid = 0; wb.ex_is_vector = 0; wb.ex_reg = '0; wb.ex_sdata = '0; wb.ex_vdata = '0; wb.ex_mask = '0;
        wb.mem_valid = 0; wb.mem_is_vector = 0; wb.mem_reg = '0; wb.mem_sdata = '0; wb.mem_vdata = '0; wb.mem_mask = '0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        wb.ex_valid = 1; wb.ex_reg = 5'd1; wb.ex_sdata = 36'h5;
        repeat (2) @(negedge clk);
        tests++;
        if (wb.s_wr_en !== 1'b0 || wb.mask !== 4'b0 || wb.s_busy !== 32'b0 || wb.mem_ready !== 1'b0) begin
            fails++; $display("FAIL reset_outputs we=%0b mask=%h s_busy=%h ready=%0b want all 0", wb.s_wr_en, wb.mask, wb.s_busy, wb.mem_ready);
        end
        rst_n = 1; #1;
        tests++;
        if (wb.mem_ready !== 1'b1 || wb.s_wr_en !== 1'b0) begin
            fails++; $display("FAIL reset_release ready=%0b we=%0b want 1 0", wb.mem_ready, wb.s_wr_en);
        end
        @(negedge clk);
        tests++;
        if (wb.s_wr_en !== 1'b1 || wb.r_write_addr !== 5'd1 || wb.write_data !== 36'h5) begin
            fails++; $display("FAIL first_write we=%0b addr=%0d data=%h want 1 1 5", wb.s_wr_en, wb.r_write_addr, wb.write_data);
        end
        idle();
        @(negedge clk);
    endtask

    task automatic test_scalar();
        wb.iss_valid = 1; wb.iss_reg = 5'd5;
        @(negedge clk); idle();
        tests++;
        if (wb.s_busy[5] !== 1'b1) begin fails++; $display("FAIL busy_set s_busy=%h want bit5", wb.s_busy); end
        wb.ex_valid = 1; wb.ex_reg = 5'd5; wb.ex_sdata = 36'h123456789;
        @(negedge clk); idle();
        tests++;
        if (wb.s_wr_en !== 1'b1 || wb.r_write_addr !== 5'd5 || wb.write_data !== 36'h123456789 || wb.s_busy[5] !== 1'b1) begin
            fails++; $display("FAIL scalar_write we=%0b addr=%0d data=%h busy5=%0b want 1 5 123456789 1", wb.s_wr_en, wb.r_write_addr, wb.write_data, wb.s_busy[5]);
        end
        @(negedge clk);
        tests++;
        if (wb.s_busy[5] !== 1'b0 || wb.s_wr_en !== 1'b0) begin
            fails++; $display("FAIL busy_clear busy5=%0b we=%0b want 0 0", wb.s_busy[5], wb.s_wr_en);
        end
    endtask

    task automatic test_merge();
        logic [3:0][31:0] ev;
        ev = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
        wb.ex_valid = 1; wb.ex_reg = 5'd3; wb.ex_sdata = 36'hA0A0;
        wb.mem_valid = 1; wb.mem_reg = 5'd7; wb.mem_sdata = 36'hB0B0;
        @(negedge clk); idle();
        tests++;
        if (wb.s_wr_en !== 1'b1 || wb.r_write_addr !== 5'd3 || wb.write_data !== 36'hA0A0) begin
            fails++; $display("FAIL merge_ex_first we=%0b addr=%0d data=%h want 1 3 a0a0", wb.s_wr_en, wb.r_write_addr, wb.write_data);
        end
        @(negedge clk);
        tests++;
        if (wb.s_wr_en !== 1'b1 || wb.r_write_addr !== 5'd7 || wb.write_data !== 36'hB0B0) begin
            fails++; $display("FAIL merge_mem_next we=%0b addr=%0d data=%h want 1 7 b0b0", wb.s_wr_en, wb.r_write_addr, wb.write_data);
        end
        @(negedge clk);
        wb.ex_valid = 1; wb.ex_reg = 5'd4; wb.ex_sdata = 36'h44;
        wb.mem_valid = 1; wb.mem_is_vector = 1; wb.mem_reg = 5'd2; wb.mem_mask = 4'b1010; wb.mem_vdata = ev;
        @(negedge clk); idle();
        wb.ex_valid = 1; wb.ex_reg = 5'd6; wb.ex_sdata = 36'h66;
        tests++;
        if (wb.s_wr_en !== 1'b1 || wb.r_write_addr !== 5'd4 || wb.mask !== 4'b0) begin
            fails++; $display("FAIL merge_push_cycle we=%0b addr=%0d mask=%b want 1 4 0000", wb.s_wr_en, wb.r_write_addr, wb.mask);
        end
        @(negedge clk); idle();
        tests++;
        if (wb.s_wr_en !== 1'b1 || wb.r_write_addr !== 5'd6 || wb.write_data !== 36'h66 ||
            wb.mask !== 4'b1010 || wb.v_write_addr !== 5'd2 || wb.write_vector !== ev) begin
            fails++; $display("FAIL dual_port we=%0b addr=%0d data=%h mask=%b vaddr=%0d vec=%h want 1 6 66 1010 2 %h",
                wb.s_wr_en, wb.r_write_addr, wb.write_data, wb.mask, wb.v_write_addr, wb.write_vector, ev);
        end
        @(negedge clk);
    endtask

    task automatic test_full();
        for (int c = 0; c < 13; c++) begin
            if (c >= 1 && c <= 6) begin
                tests++;
                if (wb.s_wr_en !== 1'b1 || wb.r_write_addr !== 5'(10 + c - 1) || wb.write_data !== 36'(512 + c - 1)) begin
                    fails++; $display("FAIL full_ex_write c=%0d we=%0b addr=%0d data=%h want 1 %0d %h", c, wb.s_wr_en, wb.r_write_addr, wb.write_data, 10 + c - 1, 512 + c - 1);
                end
            end else if (c >= 7 && c <= 11) begin
                tests++;
                if (wb.s_wr_en !== 1'b1 || wb.r_write_addr !== 5'(16 + c - 7) || wb.write_data !== 36'(256 + c - 7)) begin
                    fails++; $display("FAIL full_drain c=%0d we=%0b addr=%0d data=%h want 1 %0d %h", c, wb.s_wr_en, wb.r_write_addr, wb.write_data, 16 + c - 7, 256 + c - 7);
                end
            end else if (c == 12) begin
                tests++;
                if (wb.s_wr_en !== 1'b0) begin fails++; $display("FAIL full_idle we=%0b want 0", wb.s_wr_en); end
            end
            idle();
            if (c < 6) begin wb.ex_valid = 1; wb.ex_reg = 5'(10 + c); wb.ex_sdata = 36'(512 + c); end
            if (c <= 7) begin
                wb.mem_valid = 1; wb.mem_reg = 5'(16 + (c < 4 ? c : 4)); wb.mem_sdata = 36'(256 + (c < 4 ? c : 4));
            end
            if (c <= 8) begin
                tests++;
                if (wb.mem_ready !== ((c < 4 || c >= 7) ? 1'b1 : 1'b0)) begin
                    fails++; $display("FAIL full_ready c=%0d ready=%0b want %0b", c, wb.mem_ready, (c < 4 || c >= 7));
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_no_bypass();
        wb.ex_valid = 1; wb.ex_reg = 5'd1; wb.ex_sdata = 36'h1;
        wb.mem_valid = 1; wb.mem_reg = 5'd20; wb.mem_sdata = 36'h14;
        @(negedge clk); idle();
        wb.ex_valid = 1; wb.ex_reg = 5'd2; wb.ex_sdata = 36'h2;
        wb.mem_valid = 1; wb.mem_is_vector = 1; wb.mem_reg = 5'd3; wb.mem_mask = 4'hF; wb.mem_vdata = '1;
        @(negedge clk); idle();
        wb.ex_valid = 1; wb.ex_reg = 5'd3; wb.ex_sdata = 36'h3;
        tests++;
        if (wb.r_write_addr !== 5'd2 || wb.mask !== 4'b0) begin
            fails++; $display("FAIL nobypass_c2 addr=%0d mask=%b want 2 0000", wb.r_write_addr, wb.mask);
        end
        @(negedge clk); idle();
        tests++;
        if (wb.r_write_addr !== 5'd3 || wb.mask !== 4'b0) begin
            fails++; $display("FAIL nobypass_c3 addr=%0d mask=%b want 3 0000", wb.r_write_addr, wb.mask);
        end
        @(negedge clk);
        tests++;
        if (wb.s_wr_en !== 1'b1 || wb.r_write_addr !== 5'd20 || wb.write_data !== 36'h14 || wb.mask !== 4'b0) begin
            fails++; $display("FAIL nobypass_head we=%0b addr=%0d data=%h mask=%b want 1 20 14 0000", wb.s_wr_en, wb.r_write_addr, wb.write_data, wb.mask);
        end
        @(negedge clk);
        tests++;
        if (wb.s_wr_en !== 1'b0 || wb.mask !== 4'hF || wb.v_write_addr !== 5'd3) begin
            fails++; $display("FAIL nobypass_vec we=%0b mask=%b vaddr=%0d want 0 1111 3", wb.s_wr_en, wb.mask, wb.v_write_addr);
        end
        @(negedge clk);
    endtask

    task automatic test_set_wins();
        wb.iss_valid = 1; wb.iss_is_vector = 1; wb.iss_reg = 5'd9;
        @(negedge clk); idle();
        tests++;
        if (wb.v_busy[9] !== 1'b1) begin fails++; $display("FAIL vbusy_set v_busy=%h want bit9", wb.v_busy); end
        wb.ex_valid = 1; wb.ex_is_vector = 1; wb.ex_reg = 5'd9; wb.ex_mask = 4'b0001; wb.ex_vdata = '0;
        @(negedge clk); idle();
        wb.iss_valid = 1; wb.iss_is_vector = 1; wb.iss_reg = 5'd9;
        tests++;
        if (wb.mask !== 4'b0001 || wb.v_write_addr !== 5'd9) begin
            fails++; $display("FAIL set_wins_write mask=%b vaddr=%0d want 0001 9", wb.mask, wb.v_write_addr);
        end
        @(negedge clk); idle();
        tests++;
        if (wb.v_busy[9] !== 1'b1) begin fails++; $display("FAIL set_wins busy9=%0b want 1", wb.v_busy[9]); end
        @(negedge clk);
    endtask

    task automatic test_zero_mask();
        wb.iss_valid = 1; wb.iss_is_vector = 1; wb.iss_reg = 5'd12;
        wb.mem_valid = 1; wb.mem_is_vector = 1; wb.mem_reg = 5'd12; wb.mem_mask = 4'b0; wb.mem_vdata = '1;
        @(negedge clk); idle();
        tests++;
        if (wb.v_busy[12] !== 1'b1) begin fails++; $display("FAIL zmask_set busy12=%0b want 1", wb.v_busy[12]); end
        @(negedge clk);
        tests++;
        if (wb.mask !== 4'b0 || wb.v_busy[12] !== 1'b1) begin
            fails++; $display("FAIL zmask_write mask=%b busy12=%0b want 0000 1", wb.mask, wb.v_busy[12]);
        end
        @(negedge clk);
        tests++;
        if (wb.v_busy[12] !== 1'b0 || wb.v_busy[9] !== 1'b1) begin
            fails++; $display("FAIL zmask_clear busy12=%0b busy9=%0b want 0 1", wb.v_busy[12], wb.v_busy[9]);
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 3; c++) begin
            idle();
            wb.ex_valid = 1; wb.ex_reg = 5'(1 + c); wb.ex_sdata = 36'(c);
            wb.mem_valid = 1; wb.mem_reg = 5'(24 + c); wb.mem_sdata = 36'(c);
            wb.iss_valid = 1; wb.iss_reg = 5'(24 + c);
            @(negedge clk);
        end
        idle();
        wb.ex_valid = 1; wb.ex_reg = 5'd4;
        tests++;
        if (wb.s_busy[26:24] !== 3'b111 || wb.mem_ready !== 1'b1) begin
            fails++; $display("FAIL midreset_pre busy=%b ready=%0b want 111 1", wb.s_busy[26:24], wb.mem_ready);
        end
        rst_n = 0; #1;
        tests++;
        if (wb.s_wr_en !== 1'b0 || wb.mask !== 4'b0 || wb.s_busy !== 32'b0 || wb.v_busy !== 32'b0 || wb.mem_ready !== 1'b0) begin
            fails++; $display("FAIL midreset_async we=%0b mask=%b s_busy=%h v_busy=%h ready=%0b want all 0", wb.s_wr_en, wb.mask, wb.s_busy, wb.v_busy, wb.mem_ready);
        end
        idle();
        @(negedge clk);
        rst_n = 1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tests++;
            if (wb.s_wr_en !== 1'b0 || wb.mask !== 4'b0) begin
                fails++; $display("FAIL midreset_drain c=%0d we=%0b mask=%b want 0 0000", c, wb.s_wr_en, wb.mask);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scalar();
        test_merge();
        test_full();
        test_no_bypass();
        test_set_wins();
        test_zero_mask();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
